// File: rtl/candy_avb_test_qsys_timer_host.sv
// Avalon-MM host for the 16-bit-register interval timer: programs it, services its irq, reports ticks.
// Optional snapshot readback after each timeout is enabled by defining CANDY_TIMER_HOST_SNAPSHOT_EN.
module candy_avb_test_qsys_timer_host #(
  parameter int READ_LATENCY = 1,
  parameter int TICK_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       period_in,
  input  logic              continuous,
  input  logic              timer_irq,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snapshot,
  output logic              snapshot_valid
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RUN, S_CLR, S_GUARD, S_STOP_WR,
    S_SNAP_W, S_SNAP_RL, S_SNAP_RLW, S_SNAP_RH, S_SNAP_RHW
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         period_q, period_d;
  logic                cont_q, cont_d;
  logic                stop_q, stop_d;
  logic                stop_pend;
  logic [TICK_W-1:0]   tick_count_q, tick_count_d;

`ifdef CANDY_TIMER_HOST_SNAPSHOT_EN
  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [15:0]         snapl_q, snapl_d;
  logic [31:0]         snapshot_q, snapshot_d;
  logic                snap_vld_q, snap_vld_d;
`else
  logic                rd_unused;
  assign rd_unused = ^{avm_readdata, READ_LATENCY[0]};
`endif

  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    cont_d         = cont_q;
    tick_count_d   = tick_count_q;
    stop_pend      = stop_q | stop;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 3'd0;
    avm_writedata  = 16'h0000;
`ifdef CANDY_TIMER_HOST_SNAPSHOT_EN
    wait_d         = wait_q;
    snapl_d        = snapl_q;
    snapshot_d     = snapshot_q;
    snap_vld_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_WR_PL;
          period_d     = period_in;
          cont_d       = continuous;
          tick_count_d = '0;
        end
      end
      S_WR_PL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd2;
        avm_writedata  = period_q[15:0];
        state_d        = stop_pend ? S_STOP_WR : S_WR_PH;
      end
      S_WR_PH: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd3;
        avm_writedata  = period_q[31:16];
        state_d        = stop_pend ? S_STOP_WR : S_WR_CTRL;
      end
      // control word bits: [0] ITO, [1] CONT, [2] START, [3] STOP
      S_WR_CTRL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd1;
        avm_writedata  = {13'd0, 1'b1, cont_q, 1'b1};
        state_d        = stop_pend ? S_STOP_WR : S_RUN;
      end
      S_RUN: begin
        if (stop_pend) begin
          state_d = S_STOP_WR;
        end else if (timer_irq) begin
          state_d      = S_CLR;
          tick_count_d = tick_count_q + 1'b1;
        end
      end
      S_CLR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd0;
`ifdef CANDY_TIMER_HOST_SNAPSHOT_EN
        state_d        = S_SNAP_W;
`else
        state_d        = stop_pend ? S_STOP_WR : S_GUARD;
`endif
      end
      S_GUARD: begin
        if (stop_pend)   state_d = S_STOP_WR;
        else if (cont_q) state_d = S_RUN;
        else             state_d = S_IDLE;
      end
      S_STOP_WR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd1;
        avm_writedata  = 16'h0009;
        state_d        = S_IDLE;
      end
`ifdef CANDY_TIMER_HOST_SNAPSHOT_EN
      S_SNAP_W: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd4;
        state_d        = S_SNAP_RL;
      end
      S_SNAP_RL: begin
        avm_chipselect = 1'b1;
        avm_address    = 3'd4;
        wait_d         = '0;
        state_d        = S_SNAP_RLW;
      end
      S_SNAP_RLW: begin
        if (wait_q == WAIT_W'(READ_LATENCY - 1)) begin
          snapl_d = avm_readdata;
          state_d = S_SNAP_RH;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end
      S_SNAP_RH: begin
        avm_chipselect = 1'b1;
        avm_address    = 3'd5;
        wait_d         = '0;
        state_d        = S_SNAP_RHW;
      end
      // a stop latched during the snapshot sequence is only honoured here
      S_SNAP_RHW: begin
        if (wait_q == WAIT_W'(READ_LATENCY - 1)) begin
          snapshot_d = {avm_readdata, snapl_q};
          snap_vld_d = 1'b1;
          state_d    = stop_pend ? S_STOP_WR : S_GUARD;
        end else begin
          wait_d     = wait_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE || state_q == S_STOP_WR || state_d == S_STOP_WR)
      stop_d = 1'b0;
    else
      stop_d = stop_pend;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      stop_q       <= 1'b0;
      tick_count_q <= '0;
`ifdef CANDY_TIMER_HOST_SNAPSHOT_EN
      wait_q       <= '0;
      snapshot_q   <= 32'h0;
      snap_vld_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      stop_q       <= stop_d;
      tick_count_q <= tick_count_d;
`ifdef CANDY_TIMER_HOST_SNAPSHOT_EN
      wait_q       <= wait_d;
      snapshot_q   <= snapshot_d;
      snap_vld_q   <= snap_vld_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    period_q <= period_d;
    cont_q   <= cont_d;
`ifdef CANDY_TIMER_HOST_SNAPSHOT_EN
    snapl_q  <= snapl_d;
`endif
  end

  assign busy       = (state_q != S_IDLE);
  assign tick       = (state_q == S_CLR);
  assign tick_count = tick_count_q;
`ifdef CANDY_TIMER_HOST_SNAPSHOT_EN
  assign snapshot       = snapshot_q;
  assign snapshot_valid = snap_vld_q;
`else
  assign snapshot       = 32'h0;
  assign snapshot_valid = 1'b0;
`endif

endmodule
